// File: rtl/mole_pkg.sv
// mole_pkg: shared types, LFSR constants and width helper
// for the whack-a-mole round controller.
package mole_pkg;

  typedef enum logic [1:0] {
    GAP  = 2'd0,
    SHOW = 2'd1,
    OVER = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// mole_round_ctrl_if: game inputs from buttons/switches
// and registered outputs to the display logic.
interface mole_round_ctrl_if #(
  parameter int N_HOLES = 4,
  parameter int LVL_W   = 4,
  parameter int SCORE_W = 8
);
  logic [LVL_W-1:0]   level;
  logic               pause;
  logic [N_HOLES-1:0] hit;
  logic [N_HOLES-1:0] mole_onehot;
  logic [SCORE_W-1:0] score;
  logic [3:0]         lives;
  logic               hit_pulse;
  logic               miss_pulse;
  logic               game_over;

  modport master (
    output level, pause, hit,
    input  mole_onehot, score, lives,
    input  hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  level, pause, hit,
    output mole_onehot, score, lives,
    output hit_pulse, miss_pulse, game_over
  );
endinterface

// File: rtl/mole_lfsr.sv
// mole_lfsr: free-running 8-bit Fibonacci LFSR,
// asynchronously restarted to the seed.
module mole_lfsr
  import mole_pkg::*;
(
  input  logic       clk,
  input  logic       restart,
  output logic [7:0] lfsr
);
  logic [7:0] lfsr_d, lfsr_q;

  // shift left, feedback is the parity of the tapped bits
  always_comb lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};

  // state register
  always_ff @(posedge clk or posedge restart)
    if (restart) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;

  assign lfsr = lfsr_q;
endmodule

// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: tick prescaler, mole lifetime and game FSM.
// Optional macro WRONG_HIT_PENALTY_EN: wrong-hole hits cost a life.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int N_HOLES   = 4,
  parameter int LVL_W     = 4,
  parameter int TICK_DIV  = 100000,
  parameter int LIFE_BASE = 16,
  parameter int LIFE_STEP = 1,
  parameter int LIFE_MIN  = 2,
  parameter int GAP_TICKS = 4,
  parameter int LIVES     = 3,
  parameter int SCORE_W   = 8
)(
  input logic clk,
  input logic restart,
  mole_round_ctrl_if.slave bus
);
  localparam int TW = (clog2(TICK_DIV) < 1) ? 1 : clog2(TICK_DIV);
  localparam int IW = clog2(N_HOLES);
  localparam int PM0 = (LIFE_BASE > GAP_TICKS) ? LIFE_BASE : GAP_TICKS;
  localparam int PMAX = (PM0 > LIFE_MIN) ? PM0 : LIFE_MIN;
  localparam int PW = clog2(PMAX + 1);
  localparam int LW = clog2(LIFE_BASE) + LVL_W + 1;

  localparam logic [1:0] S_GAP  = GAP;
  localparam logic [1:0] S_SHOW = SHOW;
  localparam logic [1:0] S_OVER = OVER;

  logic [TW-1:0]      tick_cnt_d, tick_cnt_q;
  logic [1:0]         state_d, state_q;
  logic [PW-1:0]      phase_d, phase_q;
  logic [IW-1:0]      prev_d, prev_q;
  logic               prev_v_d, prev_v_q;
  logic [N_HOLES-1:0] mole_d, mole_q;
  logic [SCORE_W-1:0] score_d, score_q;
  logic [3:0]         lives_d, lives_q;
  logic               hit_p_d, hit_p_q;
  logic               miss_p_d, miss_p_q;
  logic               over_d, over_q;

  logic               tick;
  logic [7:0]         lfsr;
  logic [IW-1:0]      raw_idx, sel_idx;
  logic signed [LW-1:0] life_raw;
  logic [PW-1:0]      life;
  logic               correct;
  logic               wrong_miss;

  mole_lfsr u_lfsr (
    .clk     (clk),
    .restart (restart),
    .lfsr    (lfsr)
  );

  assign tick = !bus.pause && (tick_cnt_q == TW'(TICK_DIV - 1));
  assign correct = |(bus.hit & mole_q);

`ifdef WRONG_HIT_PENALTY_EN
  assign wrong_miss = |(bus.hit & ~mole_q);
`else
  assign wrong_miss = 1'b0;
`endif

  // level-dependent lifetime, clamped with a signed compare
  always_comb begin
    life_raw = $signed(LW'(LIFE_BASE))
             - $signed(LW'(bus.level) * LW'(LIFE_STEP));
    if (life_raw < $signed(LW'(LIFE_MIN))) life = PW'(LIFE_MIN);
    else                                   life = PW'(life_raw);
  end

  // next hole, bumped by one if it would repeat the last hole
  always_comb begin
    raw_idx = IW'(lfsr % 8'(N_HOLES));
    sel_idx = raw_idx;
    if (prev_v_q && raw_idx == prev_q)
      sel_idx = (raw_idx == IW'(N_HOLES - 1)) ? '0 : raw_idx + IW'(1);
  end

  // prescaler and game FSM next-state
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    state_d    = state_q;
    phase_d    = phase_q;
    prev_d     = prev_q;
    prev_v_d   = prev_v_q;
    mole_d     = mole_q;
    score_d    = score_q;
    lives_d    = lives_q;
    hit_p_d    = 1'b0;
    miss_p_d   = 1'b0;
    over_d     = over_q;
    if (!bus.pause)
      tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    unique case (state_q)
      S_GAP: begin
        if (tick) begin
          if (phase_q == PW'(GAP_TICKS - 1)) begin
            state_d  = S_SHOW;
            phase_d  = life;
            prev_d   = sel_idx;
            prev_v_d = 1'b1;
            mole_d   = N_HOLES'(1) << sel_idx;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      S_SHOW: begin
        if (!bus.pause) begin
          if (correct) begin
            if (!(&score_q)) score_d = score_q + SCORE_W'(1);
            hit_p_d = 1'b1;
            state_d = S_GAP;
            phase_d = '0;
            mole_d  = '0;
          end else if ((tick && phase_q <= PW'(1)) || wrong_miss) begin
            lives_d  = lives_q - 4'd1;
            miss_p_d = 1'b1;
            phase_d  = '0;
            mole_d   = '0;
            if (lives_q == 4'd1) begin
              state_d = S_OVER;
              over_d  = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else if (tick) begin
            phase_d = phase_q - PW'(1);
          end
        end
      end
      S_OVER: begin
        mole_d = '0;
        over_d = 1'b1;
      end
      default: state_d = S_GAP;
    endcase
  end

  // state and output registers, async restart
  always_ff @(posedge clk or posedge restart) begin
    if (restart) begin
      tick_cnt_q <= '0;
      state_q    <= S_GAP;
      phase_q    <= '0;
      prev_q     <= '0;
      prev_v_q   <= 1'b0;
      mole_q     <= '0;
      score_q    <= '0;
      lives_q    <= 4'(LIVES);
      hit_p_q    <= 1'b0;
      miss_p_q   <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      phase_q    <= phase_d;
      prev_q     <= prev_d;
      prev_v_q   <= prev_v_d;
      mole_q     <= mole_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      hit_p_q    <= hit_p_d;
      miss_p_q   <= miss_p_d;
      over_q     <= over_d;
    end
  end

  assign bus.mole_onehot = mole_q;
  assign bus.score       = score_q;
  assign bus.lives       = lives_q;
  assign bus.hit_pulse   = hit_p_q;
  assign bus.miss_pulse  = miss_p_q;
  assign bus.game_over   = over_q;
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl: directed checks of the round controller
// with TICK_DIV=4 (one tick every 4 clks).
module tb_mole_round_ctrl;
  logic clk = 1'b0;
  logic restart;

  always #5 clk = ~clk;

  mole_round_ctrl_if #(
    .N_HOLES(4), .LVL_W(4), .SCORE_W(8)
  ) bus ();

  mole_round_ctrl #(
    .N_HOLES(4), .LVL_W(4), .TICK_DIV(4), .SCORE_W(8)
  ) dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus.slave)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int lvl);
    restart   = 1'b1;
    bus.level = 4'(lvl);
    bus.pause = 1'b0;
    bus.hit   = '0;
    step(2);
    restart = 1'b0;
  endtask

  task automatic wait_mole(output int n);
    n = 0;
    while (bus.mole_onehot == 0 && n < 300) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_gone(output int n);
    n = 0;
    while (bus.mole_onehot != 0 && n < 300) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    int n, reps, nonhot;
    logic [3:0] cur, prev_m, m;

    // reset values and first mole latency
    restart   = 1'b1;
    bus.level = 4'd0;
    bus.pause = 1'b0;
    bus.hit   = '0;
    step(2);
    check("rst_mole", bus.mole_onehot, 0);
    check("rst_score", bus.score, 0);
    check("rst_lives", bus.lives, 3);
    check("rst_over", bus.game_over, 0);
    check("rst_pulses", {bus.hit_pulse, bus.miss_pulse}, 0);
    restart = 1'b0;
    wait_mole(n);
    check("first_mole_clks", n, 16);
    check("first_onehot", $onehot(bus.mole_onehot), 1);

    // level 1: correct hit, then a full 15-tick lifetime
    do_reset(1);
    wait_mole(n);
    cur = bus.mole_onehot;
    bus.hit = cur;
    step(1);
    bus.hit = '0;
    check("hit_score", bus.score, 1);
    check("hit_pulse", bus.hit_pulse, 1);
    check("hit_mole_off", bus.mole_onehot, 0);
    check("hit_lives", bus.lives, 3);
    step(1);
    check("hit_pulse_1cyc", bus.hit_pulse, 0);
    wait_mole(n);
    check("lvl1_mole_seen", bus.mole_onehot != 0, 1);
    wait_gone(n);
    check("life_lvl1_clks", n, 60);
    check("lvl1_lives", bus.lives, 2);
    check("lvl1_miss", bus.miss_pulse, 1);
    step(1);
    check("miss_pulse_1cyc", bus.miss_pulse, 0);

    // level 14: life clamps to 2 ticks, run out of lives
    do_reset(14);
    for (int i = 0; i < 3; i++) begin
      wait_mole(n);
      wait_gone(n);
      check("life_lvl14_clks", n, 8);
      check("lives_dec", bus.lives, 32'(2 - i));
    end
    check("over_flag", bus.game_over, 1);
    check("over_mole", bus.mole_onehot, 0);
    bus.hit = 4'hF;
    step(1);
    bus.hit = '0;
    step(1);
    check("over_hit_score", bus.score, 0);
    check("over_hit_pulse", bus.hit_pulse, 0);
    step(40);
    check("over_hold_mole", bus.mole_onehot, 0);
    check("over_hold_lives", bus.lives, 0);
    check("over_hold_flag", bus.game_over, 1);

    // pause mid-SHOW preserves the remaining lifetime
    do_reset(0);
    wait_mole(n);
    step(10);
    cur = bus.mole_onehot;
    bus.pause = 1'b1;
    bus.hit = cur;
    step(1);
    bus.hit = '0;
    step(99);
    check("pause_mole", bus.mole_onehot, 32'(cur));
    check("pause_score", bus.score, 0);
    check("pause_lives", bus.lives, 3);
    bus.pause = 1'b0;
    wait_gone(n);
    check("life_after_pause", n, 54);
    check("pause_exp_lives", bus.lives, 2);

    // correct hit in the expiry cycle wins
    do_reset(14);
    wait_mole(n);
    cur = bus.mole_onehot;
    step(7);
    bus.hit = cur;
    step(1);
    bus.hit = '0;
    check("tie_score", bus.score, 1);
    check("tie_lives", bus.lives, 3);
    check("tie_hit_pulse", bus.hit_pulse, 1);
    check("tie_miss_pulse", bus.miss_pulse, 0);
    check("tie_mole_off", bus.mole_onehot, 0);

    // 200 moles: one-hot, never the same hole twice in a row
    prev_m = cur;
    reps = 0;
    nonhot = 0;
    for (int i = 0; i < 200; i++) begin
      wait_mole(n);
      m = bus.mole_onehot;
      if (!$onehot(m)) nonhot++;
      if (m == prev_m) reps++;
      prev_m = m;
      bus.hit = m;
      step(1);
      bus.hit = '0;
    end
    check("no_repeat", reps, 0);
    check("all_onehot", nonhot, 0);
    check("run_score", bus.score, 201);
    check("run_lives", bus.lives, 3);

    // wrong-hole hit, then correct+wrong together
    do_reset(0);
    wait_mole(n);
    cur = bus.mole_onehot;
    bus.hit = ~cur;
    step(1);
    bus.hit = '0;
`ifdef WRONG_HIT_PENALTY_EN
    check("wrong_lives", bus.lives, 2);
    check("wrong_miss", bus.miss_pulse, 1);
    check("wrong_mole", bus.mole_onehot, 0);
`else
    check("wrong_lives", bus.lives, 3);
    check("wrong_miss", bus.miss_pulse, 0);
    check("wrong_mole", bus.mole_onehot, 32'(cur));
`endif
    check("wrong_score", bus.score, 0);
    wait_mole(n);
    bus.hit = 4'hF;
    step(1);
    bus.hit = '0;
    check("mixed_score", bus.score, 1);
`ifdef WRONG_HIT_PENALTY_EN
    check("mixed_lives", bus.lives, 2);
`else
    check("mixed_lives", bus.lives, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
